mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_ctrl_fsm_if.sv | 26 ++
 rtl/mc_alu_dec.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 142 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// MC_CTRL_BNE_EN adds the BNEEX state.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
`ifdef MC_CTRL_BNE_EN
    , S_BNEEX = 4'd13
`endif
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Per-cycle control bundle; alu_en gates alucontrol so idle states drive 0.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcen;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       alu_en;
    logic       err;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle.
interface mc_ctrl_fsm_if #(parameter int ALUCTRL_W = 3);
  logic [5:0]           op;
  logic [5:0]           funct;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0]           alusrcb;
  logic [1:0]           pcsrc;
  logic [ALUCTRL_W-1:0] alucontrol;
  logic [3:0]           state_o;
  logic                 err;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
           alusrcb, pcsrc, alucontrol, state_o, err
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen,
           alusrcb, pcsrc, alucontrol, state_o, err
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU decoder: aluop/funct -> alucontrol, flags unknown R-type funct.
module mc_alu_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);
  logic [2:0] code;

  always_comb begin
    code    = ALU_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  code = ALU_ADD;
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM with memory handshake and wait timeout.
// MC_CTRL_BNE_EN enables bne (op 000101) via BNEEX.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_ctrl_fsm_if.master        ctl
);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     wait_cnt;
  ctrl_t                c;
  aluop_e               aluop;
  logic [ALUCTRL_W-1:0] alu_code;
  logic                 illegal;
  logic                 waiting, timeout;

  mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .aluop      (aluop),
    .funct      (ctl.funct),
    .alucontrol (alu_code),
    .illegal    (illegal)
  );

  assign waiting = (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !ctl.mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (32'(wait_cnt) == 32'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    c       = '0;
    aluop   = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        c.mem_req = 1'b1; c.alusrcb = 2'b01; c.alu_en = 1'b1;
        if (ctl.mem_ready) begin
          c.irwrite = 1'b1; c.pcen = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout) state_d = S_HALT;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11; c.alu_en = 1'b1;
        case (ctl.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_en = 1'b1;
        state_d   = (ctl.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1; c.iord = 1'b1;
        if (ctl.mem_ready) state_d = S_MEMWB;
        else if (timeout)  state_d = S_HALT;
      end
      S_MEMWB: begin
        c.memtoreg = 1'b1; c.regwrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
        if (ctl.mem_ready) state_d = S_FETCH;
        else if (timeout)  state_d = S_HALT;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1; c.alu_en = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = illegal ? S_HALT : S_RTYPEWB;
      end
      S_RTYPEWB: begin
        c.regdst = 1'b1; c.regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1; c.alu_en = 1'b1; c.pcsrc = 2'b01; c.pcen = ctl.zero;
        aluop     = ALUOP_SUB;
        state_d   = S_FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      S_BNEEX: begin
        c.alusrca = 1'b1; c.alu_en = 1'b1; c.pcsrc = 2'b01; c.pcen = ~ctl.zero;
        aluop     = ALUOP_SUB;
        state_d   = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_en = 1'b1;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_JEX: begin
        c.pcsrc = 2'b10; c.pcen = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  c.err  = 1'b1;
      default: state_d = S_HALT;
    endcase
    // Reset is asynchronous, so outputs are squashed combinationally too.
    if (!reset) c = '0;
  end

  assign ctl.mem_req    = c.mem_req;
  assign ctl.iord       = c.iord;
  assign ctl.memwrite   = c.memwrite;
  assign ctl.irwrite    = c.irwrite;
  assign ctl.regdst     = c.regdst;
  assign ctl.memtoreg   = c.memtoreg;
  assign ctl.regwrite   = c.regwrite;
  assign ctl.alusrca    = c.alusrca;
  assign ctl.pcen       = c.pcen;
  assign ctl.alusrcb    = c.alusrcb;
  assign ctl.pcsrc      = c.pcsrc;
  assign ctl.alucontrol = c.alu_en ? alu_code : '0;
  assign ctl.state_o    = state_q;
  assign ctl.err        = c.err;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm (MEM_TIMEOUT=4); honours MC_CTRL_BNE_EN.
module tb_mc_ctrl_fsm;
  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMB = 4'd4, SMW = 4'd5,
                         SRE = 4'd6, SRW = 4'd7, SBE = 4'd8, SAE = 4'd9, SAW = 4'd10,
                         SJ = 4'd11, SH = 4'd12, SBN = 4'd13;

  function automatic logic [16:0] cv(input logic mreq, iord, mw, irw, rd, m2r, rw, asa, pcen,
                                     input logic [1:0] asb, psrc, input logic [2:0] aluc,
                                     input logic err);
    return {mreq, iord, mw, irw, rd, m2r, rw, asa, pcen, asb, psrc, aluc, err};
  endfunction

  localparam logic [16:0] ZV   = 17'd0;
  localparam logic [16:0] FW   = cv(1,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
  localparam logic [16:0] FR   = cv(1,0,0,1,0,0,0,0,1, 2'b01, 2'b00, 3'b010, 0);
  localparam logic [16:0] DEC  = cv(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
  localparam logic [16:0] MADR = cv(0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 3'b010, 0);
  localparam logic [16:0] MRD  = cv(1,1,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [16:0] MWB  = cv(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [16:0] MWR  = cv(1,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [16:0] RTWB = cv(0,0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [16:0] BEQ1 = cv(0,0,0,0,0,0,0,1,1, 2'b00, 2'b01, 3'b110, 0);
  localparam logic [16:0] BEQ0 = cv(0,0,0,0,0,0,0,1,0, 2'b00, 2'b01, 3'b110, 0);
  localparam logic [16:0] AEX  = cv(0,0,0,0,0,0,0,1,0, 2'b10, 2'b00, 3'b010, 0);
  localparam logic [16:0] AWB  = cv(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [16:0] JX   = cv(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 3'b000, 0);
  localparam logic [16:0] HLT  = cv(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1);

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] v;
    logic [15:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  mc_ctrl_fsm_if #(.ALUCTRL_W(3)) bus ();

  mc_ctrl_fsm #(.ALUCTRL_W(3), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (rst),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] step_id  = 0;
  logic [5:0]  cur_op, cur_funct;
  logic        cur_zero;
  logic [16:0] act_v;

  assign act_v = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                  bus.regwrite, bus.alusrca, bus.pcen, bus.alusrcb, bus.pcsrc, bus.alucontrol,
                  bus.err};

  // Monitor: compare every cycle that has a pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        checks++;
        if (bus.state_o !== mon_e.st || act_v !== mon_e.v) begin
          failures++;
          $display("FAIL step%0d: got state=%0d ctrl=%b, want state=%0d ctrl=%b",
                   mon_e.id, bus.state_o, act_v, mon_e.st, mon_e.v);
        end
      end
    end
  end

  task automatic instr(input logic [5:0] o, f, input logic z);
    cur_op = o; cur_funct = f; cur_zero = z;
  endtask

  task automatic step(input logic rst_v, rdy, input logic [3:0] st, input logic [16:0] v);
    rst           = rst_v;
    bus.op        = cur_op;
    bus.funct     = cur_funct;
    bus.zero      = cur_zero;
    bus.mem_ready = rdy;
    sbq.push_back('{st: st, v: v, id: step_id});
    step_id++;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] al_tab[5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    rst = 1'b0;
    instr(6'b100011, 6'd0, 1'b0);
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // reset holds everything low, even with mem_ready asserted
    step(0, 0, SF, ZV);
    step(0, 1, SF, ZV);
    // lw: fetch with 3-cycle memory delay, then full load path
    step(1, 0, SF, FW); step(1, 0, SF, FW); step(1, 0, SF, FW); step(1, 1, SF, FR);
    step(1, 0, SD, DEC); step(1, 0, SMA, MADR); step(1, 1, SMR, MRD); step(1, 0, SMB, MWB);
    // R-type functs
    for (int i = 0; i < 5; i++) begin
      instr(6'b000000, fn_tab[i], 1'b0);
      step(1, 1, SF, FR); step(1, 0, SD, DEC);
      step(1, 0, SRE, cv(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, al_tab[i], 0));
      step(1, 0, SRW, RTWB);
    end
    // beq taken / not taken
    instr(6'b000100, 6'd0, 1'b1);
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SBE, BEQ1);
    instr(6'b000100, 6'd0, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SBE, BEQ0);
    // addi, j
    instr(6'b001000, 6'd0, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SAE, AEX); step(1, 0, SAW, AWB);
    instr(6'b000010, 6'd0, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SJ, JX);
    // sw with two wait cycles
    instr(6'b101011, 6'd0, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SMA, MADR);
    step(1, 0, SMW, MWR); step(1, 0, SMW, MWR); step(1, 1, SMW, MWR);
    // sw aborted by reset during the wait
    step(1, 1, SF, FR); step(1, 0, SD, DEC); step(1, 0, SMA, MADR); step(1, 0, SMW, MWR);
    step(0, 0, SF, ZV); step(0, 0, SF, ZV);
    // illegal funct -> HALT, sticky until reset
    instr(6'b000000, 6'b000000, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC);
    step(1, 0, SRE, cv(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b000, 0));
    step(1, 1, SH, HLT); step(1, 1, SH, HLT);
    step(0, 0, SF, ZV);
    // bne opcode
    instr(6'b000101, 6'd0, 1'b0);
    step(1, 1, SF, FR); step(1, 0, SD, DEC);
`ifdef MC_CTRL_BNE_EN
    step(1, 0, SBN, BEQ1); step(1, 0, SF, FW);
`else
    step(1, 0, SH, HLT); step(1, 1, SH, HLT);
`endif
    step(0, 0, SF, ZV);
    // timeout: 4 unanswered FETCH cycles -> HALT
    step(1, 0, SF, FW); step(1, 0, SF, FW); step(1, 0, SF, FW); step(1, 0, SF, FW);
    step(1, 1, SH, HLT); step(1, 1, SH, HLT); step(1, 0, SH, HLT);
    step(0, 0, SF, ZV);
    step(1, 1, SF, FR);
    // drain: bounded wait for the monitor
    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
